// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and the
// reset-cause codes exported to firmware.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_PLL    = 2'b01;
    localparam logic [1:0] CAUSE_BUTTON = 2'b10;
    localparam logic [1:0] CAUSE_WDT    = 2'b11;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debounce counter; the accepted level
// only changes after DEBOUNCE_CYCLES consecutive differing synced samples.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic reset_in,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             meta_r;
    logic             sync_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchroniser; reset_in is active low.
    always_ff @(posedge CLK or negedge reset_in) begin
        if (!reset_in) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    // Debounce: count disagreement cycles, accept the new level at the terminal count.
    always_ff @(posedge CLK or negedge reset_in) begin
        if (!reset_in) begin
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (sync_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= ~level_r;
                cnt_r   <= CNT_ZERO;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/reset_sequencer.sv
// Core reset sequencer: stretched reset on POR, PLL loss and debounced GRESET,
// plus an optional watchdog source enabled by defining RSTSEQ_WDT_EN.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 255,
    parameter int WDT_CYCLES      = 16777216
) (
    input  logic       io_mainClk,
    input  logic       io_asyncResetn,
    input  logic       pll_locked,
    input  logic       greset,
    input  logic       io_wdtEnable,
    input  logic       io_wdtKick,
    output logic       io_coreReset,
    output logic [1:0] io_resetCause,
    output logic       io_resetting
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    state_e            state_r;
    logic              core_reset_r;
    logic [1:0]        cause_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              lock_meta_r;
    logic              lock_sync_r;
    logic              btn_db_s;
    logic              wdt_expire_s;

    // Two-flop synchroniser for the PLL lock flag (no debounce on this path).
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK     (io_mainClk),
        .reset_in(io_asyncResetn),
        .raw     (greset),
        .level   (btn_db_s)
    );

`ifdef RSTSEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
    localparam logic [WDT_W-1:0] WDT_ZERO = WDT_W'(0);

    logic [WDT_W-1:0] wdt_cnt_r;

    assign wdt_expire_s = (state_r == ST_RUN) && io_wdtEnable && !io_wdtKick &&
                          (wdt_cnt_r == WDT_LAST);

    // Watchdog counter: runs only in RUN while enabled, cleared by a kick or at expiry.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            wdt_cnt_r <= WDT_ZERO;
        end else if ((state_r != ST_RUN) || !io_wdtEnable || io_wdtKick ||
                     (wdt_cnt_r == WDT_LAST)) begin
            wdt_cnt_r <= WDT_ZERO;
        end else begin
            wdt_cnt_r <= wdt_cnt_r + WDT_ONE;
        end
    end
`else
    logic unused_wdt_s;

    assign wdt_expire_s = 1'b0;
    assign unused_wdt_s = &{1'b0, io_wdtEnable, io_wdtKick, WDT_CYCLES[0]};
`endif

    // Sequencer FSM; core_reset_r is computed from the next state so it is registered with it.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_r      <= ST_HOLD;
            core_reset_r <= 1'b1;
            cause_r      <= CAUSE_POR;
            hold_cnt_r   <= HOLD_ZERO;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (lock_sync_r && !btn_db_s) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_r      <= ST_RUN;
                            core_reset_r <= 1'b0;
                            hold_cnt_r   <= HOLD_ZERO;
                        end else begin
                            core_reset_r <= 1'b1;
                            hold_cnt_r   <= hold_cnt_r + HOLD_ONE;
                        end
                    end else begin
                        core_reset_r <= 1'b1;
                        hold_cnt_r   <= HOLD_ZERO;
                    end
                end
                ST_RUN: begin
                    hold_cnt_r <= HOLD_ZERO;
                    if (!lock_sync_r) begin
                        state_r      <= ST_HOLD;
                        core_reset_r <= 1'b1;
                        cause_r      <= CAUSE_PLL;
                    end else if (btn_db_s) begin
                        state_r      <= ST_ARMED;
                        core_reset_r <= 1'b1;
                        cause_r      <= CAUSE_BUTTON;
                    end else if (wdt_expire_s) begin
                        state_r      <= ST_HOLD;
                        core_reset_r <= 1'b1;
                        cause_r      <= CAUSE_WDT;
                    end else begin
                        core_reset_r <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    hold_cnt_r   <= HOLD_ZERO;
                    core_reset_r <= 1'b1;
                    if (!lock_sync_r) begin
                        state_r <= ST_HOLD;
                        cause_r <= CAUSE_PLL;
                    end else if (!btn_db_s) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                default: begin
                    state_r      <= ST_HOLD;
                    core_reset_r <= 1'b1;
                    hold_cnt_r   <= HOLD_ZERO;
                end
            endcase
        end
    end

    assign io_coreReset  = core_reset_r;
    assign io_resetting  = core_reset_r;
    assign io_resetCause = cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (DEBOUNCE=4, HOLD=8, WDT=16); the
// watchdog section follows RSTSEQ_WDT_EN.
module tb_reset_sequencer;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       pll     = 1'b1;
    logic       gres    = 1'b0;
    logic       wen     = 1'b0;
    logic       kick    = 1'b0;
    logic       core_reset;
    logic [1:0] cause;
    logic       resetting;

    typedef struct {
        logic       rst_n;
        logic       pll;
        logic       gres;
        logic       wen;
        logic       kick;
        int         cycles;
        logic       exp_reset;
        logic [1:0] exp_cause;
    } vec_t;

    typedef struct {
        logic       exp_reset;
        logic [1:0] exp_cause;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef RSTSEQ_WDT_EN
    localparam logic [1:0] KICK_CAUSE = 2'b11;
`else
    localparam logic [1:0] KICK_CAUSE = 2'b01;
`endif

    reset_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .WDT_CYCLES     (16)
    ) dut (
        .io_mainClk    (clk),
        .io_asyncResetn(rst_n),
        .pll_locked    (pll),
        .greset        (gres),
        .io_wdtEnable  (wen),
        .io_wdtKick    (kick),
        .io_coreReset  (core_reset),
        .io_resetCause (cause),
        .io_resetting  (resetting)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic p, logic g, logic e, logic k, int n,
                                logic er, logic [1:0] ec);
        vec_t v;
        v.rst_n = r; v.pll = p; v.gres = g; v.wen = e; v.kick = k;
        v.cycles = n; v.exp_reset = er; v.exp_cause = ec;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [1:0] got,
                         input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec%0d: got %b expected %b", name, id, got, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: empty queue got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("core_reset", e.id, {1'b0, core_reset}, {1'b0, e.exp_reset});
            check("resetting",  e.id, {1'b0, resetting},  {1'b0, e.exp_reset});
            check("cause",      e.id, cause,              e.exp_cause);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        rst_n = v.rst_n; pll = v.pll; gres = v.gres; wen = v.wen; kick = v.kick;
        e.exp_reset = v.exp_reset; e.exp_cause = v.exp_cause; e.id = id;
        sb.push_back(e);
        repeat (v.cycles) @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        exp_t e;
        // POR, glitch, button press and release
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  5, 1'b1, 2'b00));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  9, 1'b1, 2'b00));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b00));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  3, 1'b0, 2'b00));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b0, 2'b00));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  6, 1'b0, 2'b00));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  1, 1'b1, 2'b10));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13, 1'b1, 2'b10));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14, 1'b1, 2'b10));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b10));
        // PLL loss while ARMED overrides the button cause
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  7, 1'b1, 2'b10));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  2, 1'b1, 2'b10));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b1, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13, 1'b1, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b01));
        // single-cycle PLL loss from RUN
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b1, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  7, 1'b1, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b01));
`ifdef RSTSEQ_WDT_EN
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 15, 1'b0, 2'b01));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  1, 1'b1, 2'b11));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  7, 1'b1, 2'b11));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 2'b11));
`else
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 200, 1'b0, 2'b01));
`endif
        // kicked watchdog never fires
        for (int i = 0; i < 20; i++) begin
            vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, KICK_CAUSE));
            vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9, 1'b0, KICK_CAUSE));
        end
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, KICK_CAUSE));
        // enter ARMED ahead of the asynchronous reset
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b1, 2'b10));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // asynchronous reset mid-cycle in ARMED: outputs change with no clock edge
        #3;
        rst_n = 1'b0;
        gres  = 1'b0;
        e.exp_reset = 1'b1; e.exp_cause = 2'b00; e.id = 1000;
        sb.push_back(e);
        #1;
        compare_head();

        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 2'b00), 1001);
        apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 1'b1, 2'b00), 1002);
        apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 2'b00), 1003);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
